// File: rtl/int_ctrl.sv
// int_ctrl: synchronises NMI/IRQ sources, arbitrates reset > NMI > IRQ and
// presents one request plus its vector at an instruction boundary (sync).
// A watchdog aborts a service that is never acknowledged and flags tmo_err.
module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        nmi_in,
  input  logic        irq_in,
  input  logic        irq_mask,
  input  logic        sync,
  input  logic        vec_ack,
  output logic        irq,
  output logic        nmi,
  output logic        rst,
  output logic [15:0] vec,
  output logic        pend,
  output logic        busy,
  output logic        tmo_err
);

  localparam int WDW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_SERVICE} state_t;
  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ} src_t;

  state_t                 state_q, state_d;
  src_t                   src_q, src_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic                   rst_pend_q, rst_pend_d;
  logic                   nmi_lat_q, nmi_lat_d;
  logic                   tmo_err_q, tmo_err_d;
  logic                   pend_q, pend_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, irq_sync_q;
  logic                   nmi_s_d_q;

  logic nmi_s, irq_s, nmi_edge, irq_qual, any_src, others_left;

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_edge = nmi_s & ~nmi_s_d_q;
  // IRQ is a live level: re-evaluated every cycle, never latched.
  assign irq_qual = irq_s & ~irq_mask;
  assign any_src  = rst_pend_q | nmi_lat_q | irq_qual;
  assign pend_d   = rst_pend_q | nmi_lat_q | irq_qual;

  // Input synchronisers and the NMI edge-detect delay register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      nmi_sync_q <= '0;
      irq_sync_q <= '0;
      nmi_s_d_q  <= 1'b0;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_in};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_in};
      nmi_s_d_q  <= nmi_s;
    end
  end

  // Sequencer state, captured source, watchdog and request latches.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_RST;
      wdog_q     <= '0;
      rst_pend_q <= 1'b1;
      nmi_lat_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      wdog_q     <= wdog_d;
      rst_pend_q <= rst_pend_d;
      nmi_lat_q  <= nmi_lat_d;
      tmo_err_q  <= tmo_err_d;
      pend_q     <= pend_d;
    end
  end

  // Requests still outstanding once the current source is retired on ack;
  // the serviced IRQ does not count, so a held IRQ re-enters via IDLE.
  always_comb begin
    others_left = 1'b0;
    case (src_q)
      SRC_RST: others_left = nmi_lat_q | nmi_edge | irq_qual;
      SRC_NMI: others_left = rst_pend_q | nmi_edge | irq_qual;
      default: others_left = rst_pend_q | nmi_lat_q | nmi_edge;
    endcase
  end

  // Next-state logic: arbitration at sync, ack retirement and watchdog abort.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    wdog_d     = wdog_q;
    rst_pend_d = rst_pend_q;
    nmi_lat_d  = nmi_lat_q | nmi_edge;
    tmo_err_d  = tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (!pend_q) begin
          state_d = ST_IDLE;
        end else if (sync && any_src) begin
          state_d = ST_SERVICE;
          wdog_d  = '0;
          if (rst_pend_q)     src_d = SRC_RST;
          else if (nmi_lat_q) src_d = SRC_NMI;
          else                src_d = SRC_IRQ;
        end
      end
      ST_SERVICE: begin
        if (vec_ack) begin
          // A fresh NMI edge on the ack cycle keeps the latch set.
          if (src_q == SRC_RST) rst_pend_d = 1'b0;
          if (src_q == SRC_NMI) nmi_lat_d  = nmi_edge;
          wdog_d  = '0;
          state_d = others_left ? ST_PENDING : ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          // Latches stay set so the same request is retried at the next sync.
          tmo_err_d = 1'b1;
          wdog_d    = '0;
          state_d   = ST_PENDING;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_SERVICE);
  assign rst     = busy && (src_q == SRC_RST);
  assign nmi     = busy && (src_q == SRC_NMI);
  assign irq     = busy && (src_q == SRC_IRQ);
  assign pend    = pend_q;
  assign tmo_err = tmo_err_q;

  // Vector for the frozen source, zero outside SERVICE.
  always_comb begin
    vec = 16'h0000;
    if (busy) begin
      case (src_q)
        SRC_RST: vec = 16'hFFFC;
        SRC_NMI: vec = 16'hFFFA;
        default: vec = 16'hFFFE;
      endcase
    end
  end

endmodule
